reg_file_wb: RTL

REG_FILE_WB -- requirements
Module: reg_file_wb

---
 rtl/reg_file_wb.sv | 76 +++++++
 1 files changed

// File: rtl/reg_file_wb.sv
// Register file with write-back bypass and a per-register pending (scoreboard) bit.
// A source whose result has issued but not yet been written is reported busy and raises stall.
module reg_file_wb #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 8,
  localparam int unsigned AddrW = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AddrW-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AddrW-1:0]  rd_addr_a,
  input  logic [AddrW-1:0]  rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              issue_en,
  input  logic [AddrW-1:0]  issue_addr,
  output logic              busy_a,
  output logic              busy_b,
  output logic              stall
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   pending_q;
  logic [NREG-1:0]   pending_d;

  logic wr_go;
  logic hit_a;
  logic hit_b;
  logic issue_go;

  always_comb begin
    wr_go = wr_en && (wr_addr != '0);
    hit_a = wr_go && (wr_addr == rd_addr_a);
    hit_b = wr_go && (wr_addr == rd_addr_b);

    // Register 0 is reset to zero and never written, so a plain index reads zero.
    rd_data_a = hit_a ? wr_data : regs_q[rd_addr_a];
    rd_data_b = hit_b ? wr_data : regs_q[rd_addr_b];

    // A result landing this cycle is forwarded, so it no longer blocks the reader.
    busy_a = pending_q[rd_addr_a] && !(wr_en && (wr_addr == rd_addr_a));
    busy_b = pending_q[rd_addr_b] && !(wr_en && (wr_addr == rd_addr_b));
    stall  = busy_a || busy_b;

    issue_go = issue_en && !stall && (issue_addr != '0);
  end

  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    if (wr_go) begin
      regs_d[wr_addr]    = wr_data;
      pending_d[wr_addr] = 1'b0;
    end
    // Applied after the write clear: a new writer to the same register wins.
    if (issue_go) begin
      pending_d[issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

endmodule
